fft_readout_unit: RTL and testbench

Reader side of the FFT working memory. After the butterfly passes complete, it reads the 512 non-redundant output bins from the final bank in natural order and computes the squared magnitude of each bin. Results stream to the display/UART path over a valid/ready interface with full backpressure. A small credit-controlled output FIFO absorbs the fixed memory read latency.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_out_fifo.sv | 51 +++++
 rtl/fft_readout_unit.sv | 130 +++++++++++++
 tb/tb_fft_readout_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants for the FFT readout path, readout FSM encoding
// and the squared-magnitude helper.
package fft_pkg;
  localparam int N_POINTS   = 1024;
  localparam int ADDR_W     = 10;
  localparam int OUT_BINS   = 512;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int MAG_W      = 2*DATA_W;
  localparam int BIN_W      = ADDR_W-1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // re^2 + im^2; worst case (-2^15)^2 * 2 = 2^31 still fits MAG_W unsigned.
  function automatic logic [MAG_W-1:0] mag_sq(input logic [DATA_W-1:0] re,
                                              input logic [DATA_W-1:0] im);
    logic signed [MAG_W-1:0] re_x, im_x;
    re_x = {{DATA_W{re[DATA_W-1]}}, re};
    im_x = {{DATA_W{im[DATA_W-1]}}, im};
    return $unsigned(re_x * re_x) + $unsigned(im_x * im_x);
  endfunction
endpackage

// File: rtl/fft_out_fifo.sv
// fft_out_fifo: small synchronous FIFO with occupancy count; rst_n flushes
// pointers and storage so the head word reads as zero after reset.
module fft_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer/count update; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= wdata;
        r_wp        <= nxt(r_wp);
      end
      if (pop) r_rp <= nxt(r_rp);
      if (push && !pop)      r_cnt <= r_cnt + CNT_W'(1);
      else if (pop && !push) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign rdata = r_mem[r_rp];
  assign count = r_cnt;
  assign empty = (r_cnt == '0);

  // The producer's credit scheme must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && !pop && r_cnt == CNT_W'(DEPTH)));
endmodule

// File: rtl/fft_readout_unit.sv
// fft_readout_unit: reads bins 0..OUT_BINS-1 of the final FFT bank, streams
// re^2+im^2 over valid/ready. Define PEAK_DETECT_EN to add peak_mag_o and
// peak_bin_o (largest non-DC bin, lower bin wins on ties).
module fft_readout_unit
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              bank_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_memsel_o,
  input  logic [DATA_W-1:0] rd_re_i,
  input  logic [DATA_W-1:0] rd_im_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [MAG_W-1:0]  mag_o,
  output logic [BIN_W-1:0]  bin_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
`ifdef PEAK_DETECT_EN
  ,
  output logic [MAG_W-1:0]  peak_mag_o,
  output logic [BIN_W-1:0]  peak_bin_o
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int OCC_W = $clog2(FIFO_DEPTH+RD_LAT+2);
  localparam int ENT_W = 1 + BIN_W + MAG_W;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(OUT_BINS-1);

  logic [1:0]        r_state;
  logic [BIN_W-1:0]  r_cnt;       // next address to issue
  logic [BIN_W-1:0]  r_wr_bin;    // bin tag of the next word to arrive
  logic [RD_LAT:0]   r_vld_pipe;  // [0] = rd_en_o, [RD_LAT] = data arriving now
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_memsel;

  logic              w_push, w_pop, w_empty, w_credit, w_issue;
  logic [BIN_W-1:0]  w_issue_addr;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [OCC_W-1:0]  w_occ;
  logic [ENT_W-1:0]  w_wdata, w_rdata;

  // Reads not yet handed downstream: FIFO entries plus every pipeline stage,
  // including the word being pushed this cycle.
  always_comb begin
    w_occ = OCC_W'(w_fifo_cnt);
    for (int i = 0; i <= RD_LAT; i++) w_occ = w_occ + OCC_W'(r_vld_pipe[i]);
  end

  // A pop this cycle frees a slot, which keeps 1 beat/cycle with ready held high.
  assign w_pop        = valid_o && ready_i;
  assign w_credit     = w_occ < (OCC_W'(FIFO_DEPTH) + OCC_W'(w_pop));
  assign w_issue_addr = (r_state == ST_IDLE) ? '0 : r_cnt;
  // The first read goes out on the start edge so rd_en_o rises one cycle later.
  assign w_issue      = w_credit && ((r_state == ST_IDLE && start_i) || r_state == ST_READ);
  assign w_push       = r_vld_pipe[RD_LAT];
  assign w_wdata      = {(r_wr_bin == LAST_BIN), r_wr_bin, mag_sq(rd_re_i, rd_im_i)};

  // Readout FSM, read issue and arrival tagging.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wr_bin   <= '0;
      r_vld_pipe <= '0;
      r_rd_addr  <= '0;
      r_memsel   <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_issue};
      if (w_push) r_wr_bin <= r_wr_bin + BIN_W'(1);
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_state  <= ST_READ;
          r_memsel <= bank_i;
          r_cnt    <= '0;
          r_wr_bin <= '0;
        end
        ST_READ:  if (w_issue && w_issue_addr == LAST_BIN) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_pop && last_o) r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
      if (w_issue) begin
        r_rd_addr <= {1'b0, w_issue_addr};
        if (w_issue_addr != LAST_BIN) r_cnt <= w_issue_addr + BIN_W'(1);
      end
    end
  end

  fft_out_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_rdata),
    .count (w_fifo_cnt),
    .empty (w_empty)
  );

  assign rd_en_o             = r_vld_pipe[0];
  assign rd_addr_o           = r_rd_addr;
  assign rd_memsel_o         = r_memsel;
  assign valid_o             = !w_empty;
  assign {last_o, bin_o, mag_o} = w_rdata;
  assign busy_o              = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done_o              = (r_state == ST_DONE);

`ifdef PEAK_DETECT_EN
  logic [MAG_W-1:0] r_peak_mag;
  logic [BIN_W-1:0] r_peak_bin;

  // Strict compare over ascending bins keeps the lower bin on ties; DC skipped.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == ST_IDLE && start_i)) begin
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else if (w_pop && bin_o != '0 && mag_o > r_peak_mag) begin
      r_peak_mag <= mag_o;
      r_peak_bin <= bin_o;
    end
  end

  assign peak_mag_o = r_peak_mag;
  assign peak_bin_o = r_peak_bin;
`endif
endmodule

// File: tb/tb_fft_readout_unit.sv
// tb_fft_readout_unit: directed scoreboard bench for fft_readout_unit.
module tb_fft_readout_unit;
  import fft_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, bank_i = 1'b0, ready_i = 1'b1;
  logic rd_en_o, rd_memsel_o, valid_o, last_o, busy_o, done_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_re_i, rd_im_i;
  logic [MAG_W-1:0]  mag_o;
  logic [BIN_W-1:0]  bin_o;
`ifdef PEAK_DETECT_EN
  logic [MAG_W-1:0]  peak_mag_o;
  logic [BIN_W-1:0]  peak_bin_o;
`endif

  fft_readout_unit dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .bank_i(bank_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_memsel_o(rd_memsel_o),
    .rd_re_i(rd_re_i), .rd_im_i(rd_im_i), .valid_o(valid_o), .ready_i(ready_i),
    .mag_o(mag_o), .bin_o(bin_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
`ifdef PEAK_DETECT_EN
    , .peak_mag_o(peak_mag_o), .peak_bin_o(peak_bin_o)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: two banks, data valid RD_LAT=2 cycles after rd_en_o.
  logic [DATA_W-1:0] mem_re [0:1][0:N_POINTS-1];
  logic [DATA_W-1:0] mem_im [0:1][0:N_POINTS-1];
  logic [1:0]        m_v = '0;
  logic [ADDR_W-1:0] m_a [2];
  logic              m_s [2];
  always @(posedge clk) begin
    m_v    <= {m_v[0], rd_en_o};
    m_a[0] <= rd_addr_o;  m_a[1] <= m_a[0];
    m_s[0] <= rd_memsel_o; m_s[1] <= m_s[0];
  end
  assign rd_re_i = m_v[1] ? mem_re[m_s[1]][m_a[1]] : 16'h5a5a;
  assign rd_im_i = m_v[1] ? mem_im[m_s[1]][m_a[1]] : 16'h5a5a;

  // Backpressure source: ~30% ready when enabled.
  logic bp_en = 1'b0;
  always @(posedge clk) begin
    #2;
    ready_i = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Scoreboard and monitor state; entry = {last, bin, mag}.
  logic [1+BIN_W+MAG_W-1:0] sb[$];
  logic [1+BIN_W+MAG_W-1:0] prev_beat;
  logic prev_stall = 1'b0, exp_bank = 1'b0;
  int c0 = 0, test_id = 0, first_rd = -1, first_vld = -1, last_cyc = -1, done_cyc = -1;
  int done_cnt = 0, n_iss = 0, n_hs = 0, max_out = 0;

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (rd_en_o) begin
        n_iss++;
        if (first_rd < 0) first_rd = cyc - c0;
        chk("rd_memsel", rd_memsel_o, exp_bank);
        chk("rd_addr_lower_half", rd_addr_o[ADDR_W-1], 1'b0);
      end
      if (n_iss - n_hs > max_out) max_out = n_iss - n_hs;
      if (prev_stall) chk("stall_hold", {valid_o, last_o, bin_o, mag_o}, {1'b1, prev_beat});
      if (valid_o && first_vld < 0) first_vld = cyc - c0;
      if (valid_o && ready_i) begin
        n_hs++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_beat: got bin %0d, expected no beat", bin_o);
        end else chk("beat", {last_o, bin_o, mag_o}, sb.pop_front());
        if (last_o) last_cyc = cyc - c0;
        if (test_id == 2 && bin_o == 7) chk("extreme_mag_bin7", mag_o, 32'h8000_0000);
      end
      prev_stall = valid_o && !ready_i;
      prev_beat  = {last_o, bin_o, mag_o};
      if (done_o) begin done_cnt++; done_cyc = cyc - c0; end
    end
  end

  task automatic run_start(input logic bank, input int id);
    test_id = id; exp_bank = bank;
    first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
    done_cnt = 0; n_iss = 0; n_hs = 0; max_out = 0;
    bank_i = bank; start_i = 1'b1; c0 = cyc;
    tick();
    start_i = 1'b0; bank_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int i = 0;
    while (done_cnt == 0 && i < limit) begin tick(); i++; end
    chk(name, done_cnt, 1);
  endtask

  // Bank 1: re=bin, im=0 -> mag=bin^2. Bank 0 holds distinct data (mag 50).
  task automatic load_ramp();
    for (int b = 0; b < N_POINTS; b++) begin
      mem_re[0][b] = 16'd5; mem_im[0][b] = 16'd5;
      mem_re[1][b] = (b < OUT_BINS) ? 16'(b) : 16'h7fff; mem_im[1][b] = 16'd0;
    end
    sb.delete();
    for (int b = 0; b < OUT_BINS; b++)
      sb.push_back({b == OUT_BINS-1, BIN_W'(b), MAG_W'(b*b)});
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_beats"}, n_hs, OUT_BINS);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_outstanding_le4"}, 64'(max_out <= FIFO_DEPTH), 1);
    chk({tag, "_done_one_cycle"}, {done_o, busy_o}, 2'b00);
  endtask

  initial begin
    int i;
    int re, im;
    longint m;
    // Reset state
    repeat (3) tick();
    chk("reset_outputs", {rd_en_o, rd_addr_o, rd_memsel_o, valid_o, mag_o, bin_o,
                          last_o, busy_o, done_o}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_outputs", {rd_en_o, valid_o, busy_o, done_o}, 4'd0);

    // Test 1: throughput from bank 1 with ready held high
    load_ramp();
    run_start(1'b1, 1);
    chk("busy_after_start", busy_o, 1'b1);
    wait_done(2000, "t1_done_seen");
    chk("t1_first_rd_en_cycle", first_rd, 1);
    chk("t1_first_valid_cycle", first_vld, 4);
    chk("t1_last_beat_cycle", last_cyc, 515);
    chk("t1_done_cycle", done_cyc, 516);
    chk("t1_memsel_held", rd_memsel_o, 1'b1);
    check_end("t1");

    // Test 2: bank 0 under backpressure, extreme values at bin 7,
    // plus an ignored start (bank 1) at cycle 100
    sb.delete();
    for (int b = 0; b < N_POINTS; b++) begin
      re = b - 256; im = (b % 16) - 8;
      if (b == 7) begin re = -32768; im = -32768; end
      mem_re[0][b] = 16'(re); mem_im[0][b] = 16'(im);
      mem_re[1][b] = 16'd1;   mem_im[1][b] = 16'd1;
      if (b < OUT_BINS) begin
        m = longint'(re)*re + longint'(im)*im;
        sb.push_back({b == OUT_BINS-1, BIN_W'(b), MAG_W'(m)});
      end
    end
    bp_en = 1'b1;
    run_start(1'b0, 2);
    i = 0;
    while (done_cnt == 0 && i < 10000) begin
      start_i = (cyc == c0 + 100);
      bank_i  = (cyc == c0 + 100);
      tick(); i++;
    end
    start_i = 1'b0; bank_i = 1'b0;
    chk("t2_done_seen", done_cnt, 1);
    bp_en = 1'b0;
    tick();
    check_end("t2");

    // Test 3: reset at cycle 200 aborts, then a fresh start restarts at bin 0
    load_ramp();
    run_start(1'b1, 3);
    while (cyc < c0 + 200) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_cleared", {valid_o, busy_o, rd_en_o, done_o}, 4'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_fifo_flushed", {valid_o, busy_o}, 2'b00);
    end
    chk("abort_no_done", done_cnt, 0);
    load_ramp();
    run_start(1'b1, 3);
    wait_done(2000, "t3_done_seen");
    chk("t3_first_valid_cycle", first_vld, 4);
    check_end("t3");

`ifdef PEAK_DETECT_EN
    // Test 4: DC bin largest (1000), ties of 500 at bins 37 and 90
    sb.delete();
    for (int b = 0; b < N_POINTS; b++) begin
      mem_re[0][b] = 16'd0; mem_im[0][b] = 16'd0;
    end
    mem_re[0][0]  = 16'd30; mem_im[0][0]  = 16'd10;
    mem_re[0][37] = 16'd20; mem_im[0][37] = 16'd10;
    mem_re[0][90] = 16'd20; mem_im[0][90] = 16'd10;
    for (int b = 0; b < OUT_BINS; b++)
      sb.push_back({b == OUT_BINS-1, BIN_W'(b),
                    (b == 0) ? 32'd1000 : (b == 37 || b == 90) ? 32'd500 : 32'd0});
    run_start(1'b0, 4);
    wait_done(2000, "t4_done_seen");
    chk("peak_bin", peak_bin_o, 37);
    chk("peak_mag", peak_mag_o, 500);
    check_end("t4");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
